// File: rtl/simmem_pkg.sv
// Shared types, sizing constants and burst-length helpers for the simmem write path.
package simmem_pkg;

    localparam int IDWidth          = 4;
    localparam int AddrWidth        = 16;
    localparam int DataWidth        = 32;
    localparam int BurstLenW        = 8;
    localparam int MaxBurstLenField = 3;
    localparam int WRspBankCapa     = 3;
    localparam int XBurstEffLenW    = $clog2(MaxBurstLenField + 2);

    typedef struct packed {
        logic [IDWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [BurstLenW-1:0] burst_len;
    } waddr_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
    } wdata_t;

    typedef struct packed {
        logic [IDWidth-1:0]       id;
        logic [XBurstEffLenW-1:0] eff_len;
    } wburst_pending_t;

    function automatic logic [BurstLenW-1:0] clamp_burst_len_field(input logic [BurstLenW-1:0] len);
        return (len > BurstLenW'(MaxBurstLenField)) ? BurstLenW'(MaxBurstLenField) : len;
    endfunction

    // AXI length field encodes beats minus one.
    function automatic logic [XBurstEffLenW-1:0] get_effective_burst_len(input logic [BurstLenW-1:0] len);
        return XBurstEffLenW'(len) + XBurstEffLenW'(1);
    endfunction

endpackage

// File: rtl/simmem_wburst_tracker_if.sv
// Address and write-data handshake bundle between the write-burst tracker and its neighbours.
interface simmem_wburst_tracker_if;
    import simmem_pkg::*;

    waddr_t             waddr_i;
    logic               waddr_valid_i;
    logic               waddr_ready_o;
    wdata_t             wdata_i;
    logic               wdata_in_valid_i;
    logic               wdata_in_ready_o;
    wdata_t             wdata_o;
    logic               wdata_out_valid_o;
    logic               wdata_out_ready_i;
    logic               burst_done_o;
    logic [IDWidth-1:0] burst_done_id_o;
    logic               burst_done_err_o;
    logic               err_sticky_o;

    modport slave (
        input  waddr_i, waddr_valid_i, wdata_i, wdata_in_valid_i, wdata_out_ready_i,
        output waddr_ready_o, wdata_in_ready_o, wdata_o, wdata_out_valid_o,
               burst_done_o, burst_done_id_o, burst_done_err_o, err_sticky_o
    );

    modport master (
        output waddr_i, waddr_valid_i, wdata_i, wdata_in_valid_i, wdata_out_ready_i,
        input  waddr_ready_o, wdata_in_ready_o, wdata_o, wdata_out_valid_o,
               burst_done_o, burst_done_id_o, burst_done_err_o, err_sticky_o
    );
endinterface

// File: rtl/simmem_wburst_fifo.sv
// Register FIFO of pending write bursts {id, eff_len}; pointers wrap modulo Depth.
module simmem_wburst_fifo
    import simmem_pkg::*;
#(
    parameter int Depth = WRspBankCapa
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  wburst_pending_t push_data_i,
    input  logic            pop_i,
    output logic            full_o,
    output logic            empty_o,
    output wburst_pending_t head_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    wburst_pending_t r_mem [Depth];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;
    logic            w_push;
    logic            w_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
    endfunction

    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;
    assign full_o  = (r_count == CntW'(Depth));
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rptr];

    // NOTE: entry storage is not reset; occupancy alone decides validity, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_data_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= next_ptr(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= next_ptr(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/simmem_wburst_tracker.sv
// Write-burst tracker: queues accepted addresses, gates data beats, pulses completion per burst.
// Optional build macro SIMMEM_WLAST_CHECK_EN enables WLAST mismatch detection and reporting.
module simmem_wburst_tracker
    import simmem_pkg::*;
#(
    parameter int PendingCapa = WRspBankCapa
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    simmem_wburst_tracker_if.slave  bus
);

    wburst_pending_t          w_push_data;
    wburst_pending_t          w_head;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_overlen;
    logic                     w_accept;
    logic                     w_final;
    logic                     w_beat_mism;
    logic                     w_unused;
    logic [XBurstEffLenW-1:0] w_cnt_inc;

    logic [XBurstEffLenW-1:0] r_beat_cnt;
    logic                     r_done;
    logic [IDWidth-1:0]       r_done_id;
    logic                     r_err_sticky;

    assign w_overlen           = bus.waddr_i.burst_len > BurstLenW'(MaxBurstLenField);
    assign w_push_data.id      = bus.waddr_i.id;
    assign w_push_data.eff_len = get_effective_burst_len(clamp_burst_len_field(bus.waddr_i.burst_len));
    assign w_push              = bus.waddr_valid_i & ~w_full;

    // Data handshakes see only the registered empty flag, never the address channel.
    assign bus.waddr_ready_o     = ~w_full;
    assign bus.wdata_o           = bus.wdata_i;
    assign bus.wdata_out_valid_o = bus.wdata_in_valid_i & ~w_empty;
    assign bus.wdata_in_ready_o  = bus.wdata_out_ready_i & ~w_empty;

    assign w_accept  = bus.wdata_in_valid_i & bus.wdata_in_ready_o;
    assign w_cnt_inc = r_beat_cnt + XBurstEffLenW'(1);
    assign w_final   = w_accept & (w_cnt_inc == w_head.eff_len);

    simmem_wburst_fifo #(
        .Depth (PendingCapa)
    ) u_pending (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_final),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .head_o      (w_head)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_beat_cnt   <= '0;
            r_done       <= 1'b0;
            r_done_id    <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_final) begin
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= w_cnt_inc;
            end
            r_done <= w_final;
            if (w_final) begin
                r_done_id <= w_head.id;
            end
            r_err_sticky <= r_err_sticky | (w_push & w_overlen) | w_beat_mism;
        end
    end

`ifdef SIMMEM_WLAST_CHECK_EN
    logic r_mism;
    logic r_done_err;

    assign w_beat_mism = w_accept & (bus.wdata_i.last != w_final);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mism     <= 1'b0;
            r_done_err <= 1'b0;
        end else begin
            if (w_final) begin
                r_mism <= 1'b0;
            end else if (w_beat_mism) begin
                r_mism <= 1'b1;
            end
            r_done_err <= w_final & (r_mism | w_beat_mism);
        end
    end

    assign bus.burst_done_err_o = r_done_err;
    assign w_unused             = ^bus.waddr_i.addr;
`else
    assign w_beat_mism          = 1'b0;
    assign bus.burst_done_err_o = 1'b0;
    assign w_unused             = ^{bus.waddr_i.addr, bus.wdata_i.last};
`endif

    assign bus.burst_done_o    = r_done;
    assign bus.burst_done_id_o = r_done_id;
    assign bus.err_sticky_o    = r_err_sticky;

endmodule

// File: tb/tb_simmem_wburst_tracker.sv
// Directed table-driven bench for simmem_wburst_tracker, plus a hand-written mid-burst reset sequence.
module tb_simmem_wburst_tracker;
    import simmem_pkg::*;

`ifdef SIMMEM_WLAST_CHECK_EN
    localparam logic Chk = 1'b1;
`else
    localparam logic Chk = 1'b0;
`endif

    typedef struct packed {
        logic               awv;
        logic [IDWidth-1:0] aw_id;
        logic [7:0]         aw_len;
        logic               wv;
        logic               wlast;
        logic [31:0]        wdata;
        logic               ordy;
        logic               e_awr;
        logic               e_inr;
        logic               e_outv;
        logic               e_done;
        logic [IDWidth-1:0] e_id;
        logic               e_err;
        logic               e_sticky;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    simmem_wburst_tracker_if bus ();

    simmem_wburst_tracker #(
        .PendingCapa (3)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected normal end");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic awv, input int id, input int len, input logic wv, input logic wlast,
                       input logic [31:0] wdata, input logic ordy, input logic e_awr, input logic e_inr,
                       input logic e_outv, input logic e_done, input int e_id, input logic e_err,
                       input logic e_sticky);
        vec_t v;
        v.awv = awv;       v.aw_id = IDWidth'(id); v.aw_len = 8'(len);
        v.wv = wv;         v.wlast = wlast;        v.wdata = wdata;   v.ordy = ordy;
        v.e_awr = e_awr;   v.e_inr = e_inr;        v.e_outv = e_outv; v.e_done = e_done;
        v.e_id = IDWidth'(e_id); v.e_err = e_err;  v.e_sticky = e_sticky;
        vq.push_back(v);
    endtask

    task automatic drive_row(input vec_t v);
        bus.waddr_valid_i         = v.awv;
        bus.waddr_i.id            = v.aw_id;
        bus.waddr_i.addr          = 16'h1000;
        bus.waddr_i.burst_len     = v.aw_len;
        bus.wdata_in_valid_i      = v.wv;
        bus.wdata_i.data          = v.wdata;
        bus.wdata_i.strb          = '1;
        bus.wdata_i.last          = v.wlast;
        bus.wdata_out_ready_i     = v.ordy;
    endtask

    task automatic check_row(input vec_t v, input string tag);
        check({tag, " waddr_ready"}, 32'(bus.waddr_ready_o), 32'(v.e_awr));
        check({tag, " in_ready"}, 32'(bus.wdata_in_ready_o), 32'(v.e_inr));
        check({tag, " out_valid"}, 32'(bus.wdata_out_valid_o), 32'(v.e_outv));
        check({tag, " wdata_o"}, bus.wdata_o.data, v.wdata);
        check({tag, " done"}, 32'(bus.burst_done_o), 32'(v.e_done));
        check({tag, " sticky"}, 32'(bus.err_sticky_o), 32'(v.e_sticky));
        if (v.e_done) begin
            check({tag, " done_id"}, 32'(bus.burst_done_id_o), 32'(v.e_id));
            check({tag, " done_err"}, 32'(bus.burst_done_err_o), 32'(v.e_err));
        end
    endtask

    task automatic run_row(input vec_t v, input string tag);
        @(posedge clk);
        #1 drive_row(v);
        #4 check_row(v, tag);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " waddr_ready"}, 32'(bus.waddr_ready_o), 32'd1);
        check({tag, " in_ready"}, 32'(bus.wdata_in_ready_o), 32'd0);
        check({tag, " out_valid"}, 32'(bus.wdata_out_valid_o), 32'd0);
        check({tag, " done"}, 32'(bus.burst_done_o), 32'd0);
        check({tag, " done_id"}, 32'(bus.burst_done_id_o), 32'd0);
        check({tag, " done_err"}, 32'(bus.burst_done_err_o), 32'd0);
        check({tag, " sticky"}, 32'(bus.err_sticky_o), 32'd0);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        v = '0;
        v.wv = 1'b1; v.ordy = 1'b1; v.wlast = 1'b1;
        drive_row(v);

        // awv id len | wv last data ordy | awr inr outv done id err sticky
        // Beat offered before any address, then one 4-beat burst with a downstream stall.
        add(0,0,0, 1,1,32'hDEAD0000,1, 1,0,0,0,0,0,0);
        add(1,2,3, 1,0,32'hA0,1,       1,0,0,0,0,0,0);
        add(0,0,0, 1,0,32'hA0,1,       1,1,1,0,0,0,0);
        add(0,0,0, 1,0,32'hA1,1,       1,1,1,0,0,0,0);
        add(0,0,0, 1,0,32'hA2,0,       1,0,1,0,0,0,0);
        add(0,0,0, 1,0,32'hA2,1,       1,1,1,0,0,0,0);
        add(0,0,0, 1,1,32'hA3,1,       1,1,1,0,0,0,0);
        add(0,0,0, 0,0,32'h0,1,        1,0,0,1,2,0,0);
        add(0,0,0, 0,0,32'h0,1,        1,0,0,0,0,0,0);
        // Single-beat burst pushed while its beat is already waiting.
        add(1,5,0, 1,1,32'hB0,1,       1,0,0,0,0,0,0);
        add(0,0,0, 1,1,32'hB0,1,       1,1,1,0,0,0,0);
        add(0,0,0, 0,0,32'h0,1,        1,0,0,1,5,0,0);
        // Fill the queue, hold a fourth address off, then drain in order with consecutive pulses.
        add(1,1,1, 0,0,32'h0,1,        1,0,0,0,0,0,0);
        add(1,3,1, 0,0,32'h0,1,        1,1,0,0,0,0,0);
        add(1,6,1, 0,0,32'h0,1,        1,1,0,0,0,0,0);
        add(1,7,0, 1,0,32'hC0,1,       0,1,1,0,0,0,0);
        add(1,7,0, 1,1,32'hC1,1,       0,1,1,0,0,0,0);
        add(1,7,0, 1,0,32'hC2,1,       1,1,1,1,1,0,0);
        add(0,0,0, 1,1,32'hC3,1,       0,1,1,0,0,0,0);
        add(0,0,0, 1,0,32'hC4,1,       1,1,1,1,3,0,0);
        add(0,0,0, 1,1,32'hC5,1,       1,1,1,0,0,0,0);
        add(0,0,0, 1,1,32'hC6,1,       1,1,1,1,6,0,0);
        add(0,0,0, 0,0,32'h0,1,        1,0,0,1,7,0,0);
        add(0,0,0, 0,0,32'h0,1,        1,0,0,0,0,0,0);
        // Early last on beat 1 of 2; burst still ends on count.
        add(1,4,1, 0,0,32'h0,1,        1,0,0,0,0,0,0);
        add(0,0,0, 1,1,32'hD0,1,       1,1,1,0,0,0,0);
        add(0,0,0, 1,0,32'hD1,1,       1,1,1,0,0,0,Chk);
        add(0,0,0, 0,0,32'h0,1,        1,0,0,1,4,Chk,Chk);
        // Over-length request clamps to 4 beats and raises the sticky error.
        add(1,9,7, 0,0,32'h0,1,        1,0,0,0,0,0,Chk);
        add(0,0,0, 1,0,32'hE0,1,       1,1,1,0,0,0,1);
        add(0,0,0, 1,0,32'hE1,1,       1,1,1,0,0,0,1);
        add(0,0,0, 1,0,32'hE2,1,       1,1,1,0,0,0,1);
        add(0,0,0, 1,1,32'hE3,1,       1,1,1,0,0,0,1);
        add(0,0,0, 0,0,32'h0,1,        1,0,0,1,9,0,1);
        add(0,0,0, 0,0,32'h0,1,        1,0,0,0,0,0,1);

        repeat (2) @(posedge clk);
        #5 check_reset_state("in_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vq[i]) begin
            run_row(vq[i], $sformatf("row%0d", i));
        end

        // Reset during beat 3 of a 4-beat burst discards it and the partial count.
        v = '0; v.ordy = 1'b1; v.awv = 1'b1; v.aw_id = 4'hA; v.aw_len = 8'd3;
        @(posedge clk); #1 drive_row(v);
        v.awv = 1'b0; v.wv = 1'b1;
        for (int b = 0; b < 2; b++) begin
            v.wdata = 32'hF0 + 32'(b);
            @(posedge clk); #1 drive_row(v);
            #4 check({$sformatf("rst_seq beat%0d", b), " in_ready"}, 32'(bus.wdata_in_ready_o), 32'd1);
        end
        v.wdata = 32'hF2;
        @(posedge clk); #1 drive_row(v);
        #2 rst_n = 1'b0;
        #1 check_reset_state("mid_burst_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        v.wlast = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1 drive_row(v);
            #4 check_reset_state($sformatf("post_reset%0d", c));
        end
        v.awv = 1'b1; v.aw_id = 4'hB; v.aw_len = 8'd0; v.wdata = 32'hF9;
        @(posedge clk); #1 drive_row(v);
        v.awv = 1'b0;
        @(posedge clk); #1 drive_row(v);
        #4 check("post_reset accept", 32'(bus.wdata_in_ready_o), 32'd1);
        check("post_reset no_done", 32'(bus.burst_done_o), 32'd0);
        v.wv = 1'b0;
        @(posedge clk); #1 drive_row(v);
        #4 check("post_reset done", 32'(bus.burst_done_o), 32'd1);
        check("post_reset done_id", 32'(bus.burst_done_id_o), 32'hB);
        check("post_reset done_err", 32'(bus.burst_done_err_o), 32'd0);
        check("post_reset sticky", 32'(bus.err_sticky_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/simmem_wburst_tracker.md
# simmem_wburst_tracker

Write-burst tracking stage directly upstream of the simmem write response bank and delay calculator. It records accepted write addresses in arrival order and forwards write data beats only while a burst is pending. It counts the beats of each burst against its effective length and emits a one-cycle completion pulse carrying the burst's AXI ID, so downstream stages start latency accounting only once all write data has arrived.

## Interface
Parameters:
- PendingCapa, default simmem_pkg::WRspBankCapa (3): maximum number of outstanding write bursts; must be ≥1.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_ni  in  1  asynchronous active-low reset
- waddr_i  in  $bits(waddr_t)  write address request (simmem_pkg::waddr_t)
- waddr_valid_i  in  1  address valid
- waddr_ready_o  out  1  address accepted when valid&ready
- wdata_i  in  $bits(wdata_t)  write data beat (simmem_pkg::wdata_t)
- wdata_in_valid_i  in  1  upstream beat valid
- wdata_in_ready_o  out  1  upstream beat accepted when valid&ready
- wdata_o  out  $bits(wdata_t)  forwarded beat, equals wdata_i combinationally
- wdata_out_valid_o  out  1  downstream beat valid
- wdata_out_ready_i  in  1  downstream ready
- burst_done_o  out  1  one-cycle pulse: head burst fully received
- burst_done_id_o  out  IDWidth  ID of completed burst; valid with burst_done_o
- burst_done_err_o  out  1  last-flag mismatch in completed burst; valid with burst_done_o
- err_sticky_o  out  1  set on any mismatch or over-length request, cleared only by reset

## Operation
- Pending queue: FIFO of {id, eff_len}, depth PendingCapa. eff_len = get_effective_burst_len(min(burst_len, MaxBurstLenField)), width XBurstEffLenW.
- Push on waddr_valid_i & waddr_ready_o. waddr_ready_o = !full. There is no same-cycle bypass when full, even if a pop occurs.
- burst_len > MaxBurstLenField: the request is clamped to MaxBurstLenField and err_sticky_o is set on the next cycle.
- wdata_out_valid_o = wdata_in_valid_i & !empty.
- wdata_in_ready_o = wdata_out_ready_i & !empty. Both depend only on the registered empty flag, so a beat is never accepted in the cycle its address is pushed into an empty queue.
- Beat accept = wdata_in_valid_i & wdata_in_ready_o. On accept, beat_cnt (XBurstEffLenW bits) increments.
- The accepted beat is final when beat_cnt+1 == head eff_len. On the final beat:
  - pop head
  - beat_cnt ← 0
  - burst_done_o ← 1 next cycle, with the popped id.
- Mismatch: wdata_i.last ≠ (beat is final) on any accepted beat. It is accumulated in mism_q, which is cleared on pop. burst_done_err_o = mism_q | current-beat mismatch. Any mismatch sets err_sticky_o.
- Bursts terminate on count only; an early last does not end a burst.
- Simultaneous push and pop in the same cycle: the occupancy count stays unchanged and ordering is preserved.

## Timing
- Reset values:
  - waddr_ready_o=1, wdata_in_ready_o=0, wdata_out_valid_o=0
  - burst_done_o=0, burst_done_id_o=0, burst_done_err_o=0, err_sticky_o=0
  - queue empty, beat_cnt=0.
- Reset asserted mid-burst discards all pending bursts and partial counts. No completion pulse is issued for a burst interrupted by reset.
- Address-to-first-beat latency: at least 1 cycle (the push is registered).
- Final beat to burst_done_o: exactly 1 cycle, registered. Back-to-back completions produce consecutive pulses.
- The data path is combinational wdata_i→wdata_o. The ready path is combinational wdata_out_ready_i→wdata_in_ready_o. There is no path from waddr_valid_i to any data handshake signal.

## Configuration
- SIMMEM_WLAST_CHECK_EN defined: mismatch detection, burst_done_err_o and the mismatch contribution to err_sticky_o are active as above.
- SIMMEM_WLAST_CHECK_EN undefined:
  - wdata_i.last is ignored.
  - burst_done_err_o is tied to 0 and mism_q is removed.
  - err_sticky_o reflects over-length requests only.
  - Beat counting and completion timing are identical in both builds.

## Structure
- simmem_pkg gains typedef wburst_pending_t {logic [IDWidth-1:0] id; logic [XBurstEffLenW-1:0] eff_len;}.
- The clamping helper goes in simmem_pkg as function clamp_burst_len_field.
- Sub-module simmem_wburst_fifo implements the parameterised register FIFO (push, pop, full, empty, head) with wburst_pending_t entries. Read and write pointers wrap modulo PendingCapa, and occupancy is held in a $clog2(PendingCapa+1)-bit counter.
- The top module holds beat_cnt, mism_q, the done and err registers, and the handshake logic.

## Test plan
- AW id=2, len=3, then 4 beats with last only on beat 4, wdata_out_ready_i=1 → 4 beats forwarded unchanged; burst_done_o=1 with id=2, err=0 exactly one cycle after beat 4.
- Beats presented before any AW → wdata_in_ready_o=0 and wdata_out_valid_o=0. After AW len=0 is pushed, the beat is accepted the next cycle, then burst_done_o id as sent.
- Fill with 3 AWs (len=1) → waddr_ready_o=0 on the 4th. Complete 1 burst → waddr_ready_o returns to 1 one cycle after the pop; IDs complete in order.
- AW len=1, last asserted on beat 1 of 2 (WLAST_CHECK_EN) → burst still ends on beat 2 with burst_done_err_o=1 and err_sticky_o=1. Without the macro: err=0, sticky=0.
- AW len=7 → treated as 4 beats; done after beat 4; err_sticky_o=1.
- Assert rst_ni low after beat 2 of a 4-beat burst → all outputs reach their reset values immediately; after release, no spurious burst_done_o and the queue is empty.
